// File: rtl/gbt_rx_frame_checker.sv
// gbt_rx_frame_checker: checks GBT RX user frames against the loopback TX pattern, tracks frame lock,
// counts frames/errors and requests a bitslip reset on lock timeout. GBT_CHECK_ERR_CAPTURE_EN adds first-error capture.
package gbt_rx_frame_checker_pkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;
endpackage

module gbt_rx_frame_checker
    import gbt_rx_frame_checker_pkg::*;
#(
    parameter logic [83:0] STATIC_PATTERN = 84'h000bebeac1dacdcfffff,
    parameter int          LOCK_CNT       = 16,
    parameter int          UNLOCK_CNT     = 4,
    parameter int          TIMEOUT_CYC    = 400000,
    parameter int          SLIP_HOLD_CYC  = 64,
    parameter int          CNT_W          = 32
) (
    input  ckrs_t              ClkRs_ix,
    input  logic               link_ready_i,
    input  logic               rx_isdata_i,
    input  logic [83:0]        rx_data_i,
    input  logic               mode_i,
    input  logic               clear_i,
    output logic [1:0]         state_o,
    output logic               locked_o,
    output logic [CNT_W-1:0]   frame_cnt_o,
    output logic [CNT_W-1:0]   err_cnt_o,
`ifdef GBT_CHECK_ERR_CAPTURE_EN
    output logic [83:0]        first_err_data_o,
    output logic               first_err_valid_o,
`endif
    output logic               bitslip_rst_o
);
    localparam int LK_W = $clog2(LOCK_CNT + 1);
    localparam int UL_W = $clog2(UNLOCK_CNT + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SL_W = $clog2(SLIP_HOLD_CYC + 1);
    localparam logic [LK_W-1:0] LOCK_LAST   = LK_W'(LOCK_CNT - 1);
    localparam logic [UL_W-1:0] UNLOCK_LAST = UL_W'(UNLOCK_CNT - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [SL_W-1:0] SLIP_LAST   = SL_W'(SLIP_HOLD_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_LOCKED, ST_SLIP} state_t;

    logic            clk;
    logic            rst;
    state_t          state_q;
    logic            valid_q;
    logic            good_q;
    logic            mode_q;
    logic [31:0]     exp_q;
    logic [LK_W-1:0] good_cnt_q;
    logic [UL_W-1:0] bad_cnt_q;
    logic [TO_W-1:0] to_q;
    logic [SL_W-1:0] slip_q;
    logic [31:0]     w;
    logic            good_d;
`ifdef GBT_CHECK_ERR_CAPTURE_EN
    logic [83:0]     data_q;
`endif

    assign clk     = ClkRs_ix.clk;
    assign rst     = ClkRs_ix.reset;
    assign state_o = state_q;
    assign w       = rx_data_i[31:0];

    // Outside LOCKED the counter word must be well formed and follow the previous word; a mode flip is always bad.
    assign good_d = (mode_i == mode_q) &&
                    (mode_i ? (w == exp_q) && (state_q == ST_LOCKED ||
                                               (rx_data_i[63:32] == w && rx_data_i[83:64] == '0))
                            : rx_data_i == STATIC_PATTERN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            locked_o      <= 1'b0;
            bitslip_rst_o <= 1'b0;
            frame_cnt_o   <= '0;
            err_cnt_o     <= '0;
            valid_q       <= 1'b0;
            good_q        <= 1'b0;
            mode_q        <= 1'b0;
            exp_q         <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            to_q          <= '0;
            slip_q        <= '0;
`ifdef GBT_CHECK_ERR_CAPTURE_EN
            data_q            <= '0;
            first_err_data_o  <= '0;
            first_err_valid_o <= 1'b0;
`endif
        end else begin
            valid_q       <= rx_isdata_i;
            good_q        <= good_d;
            mode_q        <= mode_i;
            bitslip_rst_o <= 1'b0;
            if (rx_isdata_i)
                exp_q <= (state_q == ST_LOCKED) ? exp_q + 32'd1 : w + 32'd1;
            if (state_q == ST_LOCKED && valid_q) begin
                frame_cnt_o <= sat_inc(frame_cnt_o);
                if (!good_q)
                    err_cnt_o <= sat_inc(err_cnt_o);
            end
`ifdef GBT_CHECK_ERR_CAPTURE_EN
            data_q <= rx_data_i;
            if (state_q == ST_LOCKED && valid_q && !good_q && !first_err_valid_o) begin
                first_err_data_o  <= data_q;
                first_err_valid_o <= 1'b1;
            end
            if (clear_i) begin
                first_err_data_o  <= '0;
                first_err_valid_o <= 1'b0;
            end
`endif
            if (clear_i) begin
                frame_cnt_o <= '0;
                err_cnt_o   <= '0;
            end
            if (!link_ready_i) begin
                state_q    <= ST_IDLE;
                locked_o   <= 1'b0;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                to_q       <= '0;
                slip_q     <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_HUNT;
                        good_cnt_q <= '0;
                        to_q       <= '0;
                    end
                    ST_HUNT: begin
                        if (valid_q)
                            good_cnt_q <= good_q ? good_cnt_q + 1'b1 : '0;
                        to_q <= to_q + 1'b1;
                        if (valid_q && good_q && good_cnt_q == LOCK_LAST) begin
                            state_q   <= ST_LOCKED;
                            locked_o  <= 1'b1;
                            bad_cnt_q <= '0;
                        end else if (to_q == TO_LAST) begin
                            state_q       <= ST_SLIP;
                            slip_q        <= '0;
                            bitslip_rst_o <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (valid_q)
                            bad_cnt_q <= good_q ? '0 : bad_cnt_q + 1'b1;
                        if (valid_q && !good_q && bad_cnt_q == UNLOCK_LAST) begin
                            state_q    <= ST_HUNT;
                            locked_o   <= 1'b0;
                            good_cnt_q <= '0;
                            to_q       <= '0;
                        end
                    end
                    default: begin
                        slip_q <= slip_q + 1'b1;
                        if (slip_q == SLIP_LAST) begin
                            state_q    <= ST_HUNT;
                            good_cnt_q <= '0;
                            to_q       <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gbt_rx_frame_checker.sv
// tb_gbt_rx_frame_checker: directed bench with a frame-level reference model checked every cycle.
module tb_gbt_rx_frame_checker;
    import gbt_rx_frame_checker_pkg::*;

    localparam logic [83:0] PAT = 84'h000bebeac1dacdcfffff;
    localparam int LOCK = 16, UNLOCK = 4, TMO = 100, HOLD = 64;
    localparam int IDLE = 0, HUNT = 1, LOCKED = 2, SLIP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        link = 1'b0, isdata = 1'b0, mode = 1'b0, clr = 1'b0;
    logic [83:0] rx_data = '0;
    ckrs_t       ckrs;
    logic [1:0]  state_o;
    logic        locked_o, bitslip_rst_o;
    logic [31:0] frame_cnt_o, err_cnt_o;
`ifdef GBT_CHECK_ERR_CAPTURE_EN
    logic [83:0] first_err_data_o;
    logic        first_err_valid_o;
`endif

    int vectors = 0, miscompares = 0;

    assign ckrs = {clk, rst};
    always #5 clk = ~clk;

    gbt_rx_frame_checker #(
        .STATIC_PATTERN(PAT), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK),
        .TIMEOUT_CYC(TMO), .SLIP_HOLD_CYC(HOLD), .CNT_W(32)
    ) dut (
        .ClkRs_ix(ckrs), .link_ready_i(link), .rx_isdata_i(isdata), .rx_data_i(rx_data),
        .mode_i(mode), .clear_i(clr), .state_o(state_o), .locked_o(locked_o),
        .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o),
`ifdef GBT_CHECK_ERR_CAPTURE_EN
        .first_err_data_o(first_err_data_o), .first_err_valid_o(first_err_valid_o),
`endif
        .bitslip_rst_o(bitslip_rst_o)
    );

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a frame is judged on arrival by the phase the checker is in,
    // and the phase machine consumes that verdict one frame-clock later.
    int          ms, gc, bc, tmr, sc;
    logic [31:0] last_w;
    bit          last_mode, pv, pg, ok, mpulse;
    logic [83:0] pd, mcap;
    bit          mcapv;
    logic [31:0] mf, me;

    always @(posedge clk) begin
        if (rst) begin
            ms = IDLE; gc = 0; bc = 0; tmr = 0; sc = 0;
            last_w = '1; last_mode = 0; pv = 0; pg = 0; pd = '0;
            mf = '0; me = '0; mpulse = 0; mcap = '0; mcapv = 0;
        end else begin
            if (mode)
                ok = (rx_data[31:0] == last_w + 32'd1) &&
                     (ms == LOCKED || (rx_data[63:32] == rx_data[31:0] && rx_data[83:64] == 20'd0));
            else
                ok = (rx_data == PAT);
            if (mode != last_mode) ok = 0;
            last_mode = mode;
            if (isdata) last_w = (ms == LOCKED) ? last_w + 32'd1 : rx_data[31:0];
            mpulse = 0;
            if (ms == LOCKED && pv) begin
                if (mf != '1) mf++;
                if (!pg && me != '1) me++;
                if (!pg && !mcapv) begin mcap = pd; mcapv = 1; end
            end
            if (clr) begin mf = '0; me = '0; mcap = '0; mcapv = 0; end
            if (!link) begin
                ms = IDLE; gc = 0; bc = 0; tmr = 0; sc = 0;
            end else if (ms == IDLE) begin
                ms = HUNT; gc = 0; tmr = 0;
            end else if (ms == HUNT) begin
                if (pv) gc = pg ? gc + 1 : 0;
                if (gc == LOCK) begin ms = LOCKED; bc = 0; end
                else if (tmr == TMO - 1) begin ms = SLIP; sc = 0; mpulse = 1; end
                else tmr++;
            end else if (ms == LOCKED) begin
                if (pv) bc = pg ? 0 : bc + 1;
                if (bc == UNLOCK) begin ms = HUNT; gc = 0; tmr = 0; end
            end else begin
                if (sc == HOLD - 1) begin ms = HUNT; gc = 0; tmr = 0; end
                else sc++;
            end
            pv = isdata; pg = ok; pd = rx_data;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("state", 84'(state_o), 84'(ms));
            chk("locked", 84'(locked_o), 84'(ms == LOCKED));
            chk("bitslip", 84'(bitslip_rst_o), 84'(mpulse));
            chk("frame_cnt", 84'(frame_cnt_o), 84'(mf));
            chk("err_cnt", 84'(err_cnt_o), 84'(me));
`ifdef GBT_CHECK_ERR_CAPTURE_EN
            chk("cap_valid", 84'(first_err_valid_o), 84'(mcapv));
            chk("cap_data", first_err_data_o, mcap);
`endif
        end
    end

    initial begin
        int hunt_at, p1, p2, npulse;
        step(3);
        @(negedge clk);
        chk("rst_state", 84'(state_o), 84'd0);
        chk("rst_locked", 84'(locked_o), 84'd0);
        chk("rst_cnt", 84'(frame_cnt_o | err_cnt_o), 84'd0);
        chk("rst_bitslip", 84'(bitslip_rst_o), 84'd0);
        step(1);
        rst = 1'b0;

        // static pattern: lock two edges after the 16th good frame
        link = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            isdata = 1'b1; rx_data = PAT;
            @(negedge clk);
            chk("t1_lock_time", 84'(locked_o), 84'(k >= 18));
            step(1);
        end
        isdata = 1'b0;
        step(2);
        chk("t1_frames", 84'(frame_cnt_o), 84'd4);
        chk("t1_errs", 84'(err_cnt_o), 84'd0);
        link = 1'b0;
        step(1);
        chk("t1_idle", 84'(state_o), 84'd0);

        // counter mode with one corrupted word
        mode = 1'b1; clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
        link = 1'b1;
        for (int v = 5; v <= 60; v++) begin
            isdata = 1'b1;
            rx_data = {20'h0, 32'(v), (v == 40) ? 32'd0 : 32'(v)};
            step(1);
        end
        isdata = 1'b0;
        step(2);
        chk("t2_errs", 84'(err_cnt_o), 84'd1);
        chk("t2_locked", 84'(locked_o), 84'd1);
        chk("t2_frames", 84'(frame_cnt_o), 84'd39);

        // counter wrap while locked
        link = 1'b0;
        step(2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        link = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            isdata = 1'b1;
            rx_data = {20'h0, 32'hFFFFFFE0 + 32'(i), 32'hFFFFFFE0 + 32'(i)};
            step(1);
        end
        isdata = 1'b0;
        step(2);
        chk("t3_errs", 84'(err_cnt_o), 84'd0);
        chk("t3_locked", 84'(locked_o), 84'd1);

        // four consecutive bad frames drop back to HUNT
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        isdata = 1'b1; rx_data = '0;
        step(4);
        isdata = 1'b0;
        step(3);
        chk("t4_hunt", 84'(state_o), 84'd1);
        chk("t4_errs", 84'(err_cnt_o), 84'd4);
        link = 1'b0; mode = 1'b0;
        step(1);
        chk("t4_idle", 84'(state_o), 84'd0);
        step(1);

        // lock timeout produces periodic single-cycle bitslip requests
        hunt_at = -1; p1 = -1; p2 = -1; npulse = 0;
        link = 1'b1; isdata = 1'b1; rx_data = 84'h5a5;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (state_o == 2'd1 && hunt_at < 0) hunt_at = n;
            if (bitslip_rst_o) begin
                npulse++;
                if (p1 < 0) p1 = n;
                else if (p2 < 0) p2 = n;
            end
            step(1);
        end
        chk("t5_first_pulse", 84'(p1 - hunt_at), 84'd100);
        chk("t5_period", 84'(p2 - p1), 84'd164);
        chk("t5_npulse", 84'(npulse), 84'd2);
        link = 1'b0; isdata = 1'b0;
        step(2);

        // clear against a simultaneous increment, then error capture
        link = 1'b1; isdata = 1'b1; rx_data = PAT;
        step(25);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        @(negedge clk);
        chk("t6_clear", 84'(frame_cnt_o), 84'd0);
        step(1);
        @(negedge clk);
        chk("t6_after_clear", 84'(frame_cnt_o), 84'd1);
        step(1);
        rx_data = 84'hA;
        step(1);
        rx_data = PAT;
        step(2);
        rx_data = 84'hB;
        step(1);
        rx_data = PAT;
        step(3);
        isdata = 1'b0;
        step(2);
        chk("t6_errs", 84'(err_cnt_o), 84'd2);
        chk("t6_locked", 84'(locked_o), 84'd1);
`ifdef GBT_CHECK_ERR_CAPTURE_EN
        chk("t6_cap_data", first_err_data_o, 84'hA);
        chk("t6_cap_valid", 84'(first_err_valid_o), 84'd1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        @(negedge clk);
        chk("t6_cap_clear", 84'(first_err_valid_o), 84'd0);
`endif
        link = 1'b0;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
